// File: rtl/pdm_capture_ctrl.sv
// Stereo PDM capture sequencer: PDM clock/strobes, start-up frame discard, L/R PCM frame FIFO.
// Optional mute input when PDM_CTRL_MUTE_EN is defined (muted frames carry 32'h0).
module pdm_capture_ctrl #(
  parameter int CLK_DIV    = 20,
  parameter int DECIM      = 128,
  parameter int SETTLE     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        ovf_clr,
  input  logic        pdm_din,
`ifdef PDM_CTRL_MUTE_EN
  input  logic        mute,
`endif
  output logic        pdm_clk,
  output logic        stb_left,
  output logic        stb_right,
  output logic        bit_left,
  output logic        bit_right,
  output logic        stb_pcm,
  input  logic [15:0] pcm_left,
  input  logic [15:0] pcm_right,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        overflow,
  output logic [1:0]  state
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DECIM);
  localparam int SW = $clog2(SETTLE + 2);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [PW-1:0] PH_LAST     = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HALF     = PW'(CLK_DIV / 2);
  localparam logic [PW-1:0] PH_LEFT     = PW'(CLK_DIV / 2 - 3);
  localparam logic [PW-1:0] PH_RIGHT    = PW'(CLK_DIV - 2);
  localparam logic [BW-1:0] BIT_LAST    = BW'(DECIM - 1);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE);
  localparam logic [CW-1:0] FULL_CNT    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETTLE = 2'b01,
    S_RUN    = 2'b10
  } state_t;

  state_t          st, st_nxt;
  logic [PW-1:0]   ph, ph_nxt;
  logic [BW-1:0]   bit_cnt, bit_nxt;
  logic [SW-1:0]   settle_cnt, settle_nxt;
  logic            cap_pend;
  logic            capture;
  logic            active_nxt;

  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic            pop, push, push_do, drop, full;
  logic [31:0]     push_data, head_nxt;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    st_nxt     = st;
    ph_nxt     = '0;
    bit_nxt    = '0;
    settle_nxt = settle_cnt;
    capture    = 1'b0;
    case (st)
      S_IDLE: begin
        if (enable) begin
          st_nxt     = (SETTLE == 0) ? S_RUN : S_SETTLE;
          settle_nxt = SETTLE_INIT;
        end
      end
      default: begin
        if (!enable) begin
          st_nxt = S_IDLE;
        end else begin
          ph_nxt  = (ph == PH_LAST) ? '0 : ph + PW'(1);
          bit_nxt = bit_cnt;
          if (ph == PH_LAST) bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
          // Filter output is valid one cycle after the decimation strobe.
          if (cap_pend) begin
            capture = 1'b1;
            if (st == S_SETTLE) begin
              settle_nxt = settle_cnt - SW'(1);
              if (settle_cnt == SW'(1)) st_nxt = S_RUN;
            end
          end
        end
      end
    endcase
  end

  assign active_nxt = (st_nxt != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      ph         <= '0;
      bit_cnt    <= '0;
      settle_cnt <= '0;
      cap_pend   <= 1'b0;
    end else begin
      st         <= st_nxt;
      ph         <= ph_nxt;
      bit_cnt    <= bit_nxt;
      settle_cnt <= settle_nxt;
      cap_pend   <= stb_pcm && active_nxt;
    end
  end

  assign state = st;

`ifdef PDM_CTRL_MUTE_EN
  assign push_data = mute ? 32'h0 : {pcm_left, pcm_right};
`else
  assign push_data = {pcm_left, pcm_right};
`endif

  assign pop       = m_valid && m_ready;
  assign full      = (count == FULL_CNT);
  assign push      = capture && (st == S_RUN);
  assign push_do   = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign wr_nxt    = wr_ptr + AW'(push_do);
  assign rd_nxt    = rd_ptr + AW'(pop);
  assign count_nxt = count + CW'(push_do) - CW'(pop);
  // The head after this edge may be the word being written right now.
  assign head_nxt  = (push_do && (wr_ptr == rd_nxt)) ? push_data : mem[rd_nxt];

  // NOTE: FIFO storage is not reset; occupancy and pointers alone define which words are valid.
  always_ff @(posedge clk) begin
    if (push_do) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pdm_clk   <= 1'b0;
      stb_left  <= 1'b0;
      stb_right <= 1'b0;
      bit_left  <= 1'b0;
      bit_right <= 1'b0;
      stb_pcm   <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      overflow  <= 1'b0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      count     <= count_nxt;
      pdm_clk   <= active_nxt && (ph_nxt >= PH_HALF);
      stb_left  <= active_nxt && (ph_nxt == PH_LEFT);
      stb_right <= active_nxt && (ph_nxt == PH_RIGHT);
      stb_pcm   <= active_nxt && (ph_nxt == PH_LAST) && (bit_nxt == BIT_LAST);
      if (active_nxt && (ph_nxt == PH_LEFT))  bit_left  <= pdm_din;
      if (active_nxt && (ph_nxt == PH_RIGHT)) bit_right <= pdm_din;
      m_valid   <= (count_nxt != '0);
      m_data    <= (count_nxt == '0) ? '0 : head_nxt;
      overflow  <= drop || (overflow && !ovf_clr);
    end
  end

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Self-checking bench for pdm_capture_ctrl: cycle model of strobes/state plus a frame scoreboard.
module tb_pdm_capture_ctrl;
  localparam int CLK_DIV    = 20;
  localparam int DECIM      = 4;
  localparam int SETTLE     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = CLK_DIV * DECIM;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, ovf_clr = 1'b0;
  logic        pdm_din = 1'b0, mute = 1'b0, m_ready = 1'b0;
  logic [15:0] pcm_left = '0, pcm_right = '0;
  logic        pdm_clk, stb_left, stb_right, bit_left, bit_right, stb_pcm;
  logic        m_valid, overflow;
  logic [31:0] m_data;
  logic [1:0]  state;

  int n_checks = 0, n_pass = 0, n_hs = 0;
  logic [31:0] q[$];
  int  m_st = 0, m_ph = 0, m_bit = 0, m_settle = 0;
  bit  m_cap = 0, m_ovf = 0, ovf_n, prev_din = 0, act, stb_exp, fixed_pcm = 1;
  logic [31:0] frame;

  pdm_capture_ctrl #(
    .CLK_DIV(CLK_DIV), .DECIM(DECIM), .SETTLE(SETTLE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ovf_clr(ovf_clr), .pdm_din(pdm_din),
`ifdef PDM_CTRL_MUTE_EN
    .mute(mute),
`endif
    .pdm_clk(pdm_clk), .stb_left(stb_left), .stb_right(stb_right),
    .bit_left(bit_left), .bit_right(bit_right), .stb_pcm(stb_pcm),
    .pcm_left(pcm_left), .pcm_right(pcm_right),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .overflow(overflow), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  initial begin : din_drive
    forever begin
      @(posedge clk);
      #1 pdm_din = 1'($urandom);
    end
  end

  // Reference model: evaluated mid-cycle, compares this cycle then advances across the next edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_outs", {pdm_clk, stb_left, stb_right, bit_left, bit_right, stb_pcm,
                           m_valid, overflow, state}, '0);
        check("rst_data", m_data, '0);
        m_st = 0; m_ph = 0; m_bit = 0; m_settle = 0; m_cap = 0; m_ovf = 0;
        q.delete();
        prev_din = pdm_din;
        continue;
      end
      act     = (m_st != 0);
      stb_exp = act && (m_ph == CLK_DIV - 1) && (m_bit == DECIM - 1);
      check("state", state, m_st);
      check("pdm_clk", pdm_clk, act && (m_ph >= CLK_DIV / 2));
      check("stb_left", stb_left, act && (m_ph == CLK_DIV / 2 - 3));
      check("stb_right", stb_right, act && (m_ph == CLK_DIV - 2));
      check("stb_pcm", stb_pcm, stb_exp);
      if (act && (m_ph == CLK_DIV / 2 - 3)) check("bit_left", bit_left, prev_din);
      if (act && (m_ph == CLK_DIV - 2))     check("bit_right", bit_right, prev_din);
      check("m_valid", m_valid, q.size() != 0);
      check("overflow", overflow, m_ovf);
      if (q.size() != 0) check("m_data", m_data, q[0]);
      if (m_valid && m_ready) n_hs++;

      if (m_ready && q.size() != 0) void'(q.pop_front());
      ovf_n = m_ovf && !ovf_clr;
      if (m_st == 0) begin
        if (enable) begin
          m_st = 1;
          m_settle = SETTLE;
        end
      end else if (!enable) begin
        m_st = 0; m_ph = 0; m_bit = 0; m_cap = 0;
      end else begin
        if (m_cap) begin
          frame = {pcm_left, pcm_right};
`ifdef PDM_CTRL_MUTE_EN
          if (mute) frame = '0;
`endif
          if (m_st == 1) begin
            m_settle--;
            if (m_settle == 0) m_st = 2;
          end else if (q.size() < FIFO_DEPTH) q.push_back(frame);
          else ovf_n = 1;
        end
        m_cap = stb_exp;
        if (m_ph == CLK_DIV - 1) begin
          m_ph = 0;
          m_bit = (m_bit + 1) % DECIM;
        end else m_ph++;
      end
      m_ovf = ovf_n;
      prev_din = pdm_din;
      // New filter output appears with each decimation strobe and holds through its capture.
      if (stb_exp) begin
        if (fixed_pcm) begin
          pcm_left = 16'h1234; pcm_right = 16'hABCD;
        end else begin
          pcm_left = 16'($urandom); pcm_right = 16'($urandom);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int t;
    int hs0;
    step(3);
    check("reset_state", state, 2'b00);
    check("reset_valid", m_valid, 1'b0);
    rst_n = 1'b1;
    step(100);
    check("idle_pdm_clk", pdm_clk, 1'b0);

    // Fixed data streaming with consumer always ready.
    m_ready = 1'b1;
    enable  = 1'b1;
    step(2);
    check("settle_state", state, 2'b01);
    step(8 * FRAME);
    check("run_state", state, 2'b10);

    // Random data, stall the consumer long enough to overflow.
    fixed_pcm = 0;
    m_ready = 1'b0;
    step(6 * FRAME + 10);
    check("ovf_set", overflow, 1'b1);
    check("ovf_full_valid", m_valid, 1'b1);
    m_ready = 1'b1;
    step(6 * FRAME);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    step(1);
    check("ovf_clear", overflow, 1'b0);

    // Disable with two frames queued; they must still drain.
    m_ready = 1'b0;
    t = 0;
    while (q.size() < 2 && t < 5 * FRAME) begin
      step(1);
      t++;
    end
    check("queued_two_tmo", q.size() >= 2, 1'b1);
    step(30);
    enable = 1'b0;
    step(1);
    check("dis_state", state, 2'b00);
    check("dis_pdm_clk", pdm_clk, 1'b0);
    hs0 = n_hs;
    m_ready = 1'b1;
    step(10);
    check("dis_drain", n_hs - hs0, 2);
    check("dis_empty", m_valid, 1'b0);
    step(50);
    enable = 1'b1;
    step(6 * FRAME);

    // Asynchronous reset mid-frame with data queued.
    m_ready = 1'b0;
    step(2 * FRAME + 25);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_outs", {pdm_clk, stb_left, stb_right, stb_pcm, m_valid, overflow, state}, '0);
    check("async_data", m_data, '0);
    step(1);
    rst_n = 1'b1;
    m_ready = 1'b1;
    step(5 * FRAME);

`ifdef PDM_CTRL_MUTE_EN
    mute = 1'b1;
    step(4 * FRAME);
    mute = 1'b0;
    step(2 * FRAME);
`endif

    enable = 1'b0;
    step(20);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
